// File: rtl/fiber_pkg.sv
// Shared definitions for the fiber cache request arbiter: request-type codes,
// arbiter FSM states and small type-decoding helpers.
package fiber_pkg;

  localparam logic [3:0] REQ_FETCH   = 4'b0001;
  localparam logic [3:0] REQ_READ    = 4'b0010;
  localparam logic [3:0] REQ_WRITE   = 4'b0100;
  localparam logic [3:0] REQ_CONSUME = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_RESP = 2'd2
  } state_e;

  function automatic logic is_onehot4(input logic [3:0] t);
    return (t != 4'b0000) && ((t & (t - 4'd1)) == 4'b0000);
  endfunction

  // READ and CONSUME return one data beat; FETCH and WRITE are posted.
  function automatic logic needs_resp(input logic [3:0] t);
    return (t == REQ_READ) || (t == REQ_CONSUME);
  endfunction

endpackage

// File: rtl/fiber_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above rr_ptr_i,
// wrapping at NUM_PE.
module fiber_rr_arbiter #(
  parameter  int unsigned NUM_PE = 4,
  localparam int unsigned IDW    = $clog2(NUM_PE)
) (
  input  logic [NUM_PE-1:0] req_i,
  input  logic [IDW-1:0]    rr_ptr_i,
  output logic              gnt_valid_o,
  output logic [IDW-1:0]    gnt_id_o
);

  int unsigned    idx;
  logic [IDW-1:0] idx_w;

  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_id_o    = '0;
    idx         = 0;
    idx_w       = '0;
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      idx = 32'(rr_ptr_i) + i;
      if (idx >= NUM_PE) idx = idx - NUM_PE;
      idx_w = IDW'(idx);
      if (!gnt_valid_o && req_i[idx_w]) begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = idx_w;
      end
    end
  end

endmodule

// File: rtl/fiber_req_arbiter.sv
// Shares the fiber cache PE-side request port between NUM_PE requesters:
// round-robin grant, latched issue, and single-beat response routing.
module fiber_req_arbiter
  import fiber_pkg::*;
#(
  parameter  int unsigned NUM_PE     = 4,
  parameter  int unsigned ADDR_WIDTH = 64,
  parameter  int unsigned DATA_WIDTH = 16,
  localparam int unsigned IDW        = $clog2(NUM_PE)
) (
  input  logic                       i_clk,
  input  logic                       i_nreset,
  input  logic [NUM_PE-1:0]          i_pe_valid,
  output logic [NUM_PE-1:0]          o_pe_ready,
  input  logic [4*NUM_PE-1:0]        i_pe_req_type,
  input  logic [ADDR_WIDTH*NUM_PE-1:0] i_pe_addr,
  input  logic [DATA_WIDTH*NUM_PE-1:0] i_pe_wdata,
  output logic [DATA_WIDTH-1:0]      o_pe_rdata,
  output logic [NUM_PE-1:0]          o_pe_rvalid,
  input  logic [NUM_PE-1:0]          i_pe_rready,
  output logic [3:0]                 o_request_type,
  output logic [ADDR_WIDTH-1:0]      o_addr,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic                       o_type_valid,
  input  logic                       i_type_ready,
  input  logic [DATA_WIDTH-1:0]      i_cache_data,
  input  logic                       i_cache_data_valid,
  output logic                       o_cache_data_ready,
  output logic [IDW-1:0]             o_grant_id,
  output logic                       o_busy,
  output logic                       o_err
);

  state_e                 state_q;
  logic [IDW-1:0]         rr_ptr_q;
  logic [IDW-1:0]         grant_q;
  logic [3:0]             type_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  data_q;

  logic                   gnt_valid;
  logic [IDW-1:0]         gnt_id;
  logic [IDW-1:0]         rr_ptr_d;
  logic [3:0]             sel_type;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [NUM_PE-1:0]      gnt_onehot;
  logic [NUM_PE-1:0]      owner_onehot;
  logic                   idle_take;
  logic                   in_resp;

  fiber_rr_arbiter #(.NUM_PE(NUM_PE)) u_rr (
    .req_i       (i_pe_valid),
    .rr_ptr_i    (rr_ptr_q),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  always_comb begin
    sel_type     = '0;
    sel_addr     = '0;
    sel_data     = '0;
    gnt_onehot   = '0;
    owner_onehot = '0;
    for (int unsigned k = 0; k < NUM_PE; k++) begin
      if (gnt_id == IDW'(k)) begin
        sel_type      = i_pe_req_type[k*4 +: 4];
        sel_addr      = i_pe_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data      = i_pe_wdata[k*DATA_WIDTH +: DATA_WIDTH];
        gnt_onehot[k] = 1'b1;
      end
      if (grant_q == IDW'(k)) owner_onehot[k] = 1'b1;
    end
  end

  assign rr_ptr_d = (gnt_id == IDW'(NUM_PE - 1)) ? '0 : gnt_id + 1'b1;

  // The accept handshake is combinational; gating with the reset net keeps it
  // quiet while reset is held, matching the registered outputs.
  assign idle_take = (state_q == ST_IDLE) && gnt_valid && i_nreset;
  assign in_resp   = (state_q == ST_WAIT_RESP);

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      type_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            grant_q  <= gnt_id;
            rr_ptr_q <= rr_ptr_d;
            type_q   <= sel_type;
            addr_q   <= sel_addr;
            data_q   <= sel_data;
            if (is_onehot4(sel_type)) state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (i_type_ready) state_q <= needs_resp(type_q) ? ST_WAIT_RESP : ST_IDLE;
        end
        ST_WAIT_RESP: begin
          if (i_cache_data_valid && i_pe_rready[grant_q]) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_pe_ready         = idle_take ? gnt_onehot : '0;
  assign o_err              = idle_take && !is_onehot4(sel_type);
  assign o_type_valid       = (state_q == ST_ISSUE);
  assign o_busy             = (state_q != ST_IDLE);
  assign o_request_type     = type_q;
  assign o_addr             = addr_q;
  assign o_data             = data_q;
  assign o_grant_id         = grant_q;
  assign o_pe_rvalid        = (in_resp && i_cache_data_valid) ? owner_onehot : '0;
  assign o_pe_rdata         = in_resp ? i_cache_data : '0;
  assign o_cache_data_ready = in_resp && i_pe_rready[grant_q];

endmodule

// File: tb/tb_fiber_req_arbiter.sv
// Directed bench for fiber_req_arbiter: stimulus pushes expected grants, issues
// and responses into queues that a negedge monitor pops and compares.
module tb_fiber_req_arbiter;
  import fiber_pkg::*;

  localparam int unsigned NP = 4;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = 2;

  logic              i_clk = 1'b0;
  logic              i_nreset = 1'b0;
  logic [NP-1:0]     i_pe_valid = '0;
  logic [NP-1:0]     o_pe_ready;
  logic [4*NP-1:0]   i_pe_req_type = '0;
  logic [AW*NP-1:0]  i_pe_addr = '0;
  logic [DW*NP-1:0]  i_pe_wdata = '0;
  logic [DW-1:0]     o_pe_rdata;
  logic [NP-1:0]     o_pe_rvalid;
  logic [NP-1:0]     i_pe_rready = '1;
  logic [3:0]        o_request_type;
  logic [AW-1:0]     o_addr;
  logic [DW-1:0]     o_data;
  logic              o_type_valid;
  logic              i_type_ready = 1'b1;
  logic [DW-1:0]     i_cache_data = '0;
  logic              i_cache_data_valid = 1'b0;
  logic              o_cache_data_ready;
  logic [IW-1:0]     o_grant_id;
  logic              o_busy;
  logic              o_err;

  fiber_req_arbiter #(.NUM_PE(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk              (i_clk),
    .i_nreset           (i_nreset),
    .i_pe_valid         (i_pe_valid),
    .o_pe_ready         (o_pe_ready),
    .i_pe_req_type      (i_pe_req_type),
    .i_pe_addr          (i_pe_addr),
    .i_pe_wdata         (i_pe_wdata),
    .o_pe_rdata         (o_pe_rdata),
    .o_pe_rvalid        (o_pe_rvalid),
    .i_pe_rready        (i_pe_rready),
    .o_request_type     (o_request_type),
    .o_addr             (o_addr),
    .o_data             (o_data),
    .o_type_valid       (o_type_valid),
    .i_type_ready       (i_type_ready),
    .i_cache_data       (i_cache_data),
    .i_cache_data_valid (i_cache_data_valid),
    .o_cache_data_ready (o_cache_data_ready),
    .o_grant_id         (o_grant_id),
    .o_busy             (o_busy),
    .o_err              (o_err)
  );

  always #5 i_clk = ~i_clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic [4:0]  gq[$];   // {o_pe_ready, o_err}
  logic [85:0] iq[$];   // {type, addr, data, grant_id}
  logic [21:0] rq[$];   // {o_pe_rvalid, o_pe_rdata, grant_id}

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [3:0] t, input logic [63:0] a, input logic [15:0] d);
    i_pe_req_type[k*4 +: 4] = t;
    i_pe_addr[k*AW +: AW]   = a;
    i_pe_wdata[k*DW +: DW]  = d;
    i_pe_valid[k]           = 1'b1;
  endtask

  task automatic clr_req(input int k);
    i_pe_valid[k] = 1'b0;
  endtask

  task automatic exp_req(input int k, input logic [3:0] t, input logic [63:0] a,
                         input logic [15:0] d, input logic err);
    logic [3:0] oh;
    oh = 4'b0001 << k;
    gq.push_back({oh, err});
    if (!err) iq.push_back({t, a, d, IW'(k)});
  endtask

  task automatic exp_resp(input int k, input logic [15:0] d);
    logic [3:0] oh;
    oh = 4'b0001 << k;
    rq.push_back({oh, d, IW'(k)});
  endtask

  // Waits (bounded) for the grant to PE k, then moves to the following cycle.
  task automatic wait_grant(input int k);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 16 && !got; c++) begin
      @(negedge i_clk);
      got = o_pe_ready[k];
    end
    if (!got) begin
      n_total++;
      $display("FAIL wait_grant_pe%0d: got no o_pe_ready within 16 cycles, expected a grant", k);
    end
    step();
  endtask

  always @(negedge i_clk) begin
    if (i_nreset === 1'b1) begin
      if ((|o_pe_ready) || o_err) begin
        if (gq.size() == 0) begin
          n_total++;
          $display("FAIL grant_unexpected: got ready=%b err=%b expected no grant", o_pe_ready, o_err);
        end else chk("grant", {o_pe_ready, o_err}, gq.pop_front());
      end
      if (o_type_valid && i_type_ready) begin
        if (iq.size() == 0) begin
          n_total++;
          $display("FAIL issue_unexpected: got type=%b addr=%0h expected no issue", o_request_type, o_addr);
        end else chk("issue", {o_request_type, o_addr, o_data, o_grant_id}, iq.pop_front());
      end
      if ((|o_pe_rvalid) && o_cache_data_ready) begin
        if (rq.size() == 0) begin
          n_total++;
          $display("FAIL resp_unexpected: got rvalid=%b rdata=%0h expected no response", o_pe_rvalid, o_pe_rdata);
        end else chk("resp", {o_pe_rvalid, o_pe_rdata, o_grant_id}, rq.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    #3;
    chk("rst_pe_ready", o_pe_ready, 0);
    chk("rst_type_valid", o_type_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err, 0);
    chk("rst_fields", {o_request_type, o_addr, o_data}, 0);
    chk("rst_grant_id", o_grant_id, 0);
    chk("rst_rvalid", o_pe_rvalid, 0);
    chk("rst_cdr", o_cache_data_ready, 0);
    step(); step();
    i_nreset = 1'b1;
    step();

    // Single posted FETCH from PE2
    set_req(2, REQ_FETCH, 64'h0000_0000_FFFF_FFFF, 16'h1111);
    exp_req(2, REQ_FETCH, 64'h0000_0000_FFFF_FFFF, 16'h1111, 1'b0);
    wait_grant(2);
    clr_req(2);
    @(negedge i_clk);
    chk("t1_type_valid", o_type_valid, 1);
    chk("t1_no_ready", o_pe_ready, 0);
    step();
    @(negedge i_clk);
    chk("t1_busy_low", o_busy, 0);
    chk("t1_tv_low", o_type_valid, 0);
    step();

    // READ from PE1, beat of zero three cycles after issue
    set_req(1, REQ_READ, 64'h0000_0000_0000_00A0, 16'h0);
    exp_req(1, REQ_READ, 64'h0000_0000_0000_00A0, 16'h0, 1'b0);
    exp_resp(1, 16'h0000);
    wait_grant(1);
    clr_req(1);
    @(negedge i_clk); chk("t2_gid_issue", o_grant_id, 1);
    step();
    @(negedge i_clk);
    chk("t2_gid_w1", o_grant_id, 1);
    chk("t2_rvalid_idle", o_pe_rvalid, 0);
    chk("t2_busy", o_busy, 1);
    step();
    @(negedge i_clk); chk("t2_gid_w2", o_grant_id, 1);
    step();
    i_cache_data = 16'h0000; i_cache_data_valid = 1'b1;
    @(negedge i_clk);
    chk("t2_gid_resp", o_grant_id, 1);
    chk("t2_rvalid", o_pe_rvalid, 4'b0010);
    step();
    i_cache_data_valid = 1'b0;
    @(negedge i_clk); chk("t2_idle_after", o_busy, 0);
    step();

    // CONSUME from PE3 with response back-pressure; PE0 waits meanwhile
    set_req(3, REQ_CONSUME, 64'hDEAD_BEEF_0000_0003, 16'h0);
    exp_req(3, REQ_CONSUME, 64'hDEAD_BEEF_0000_0003, 16'h0, 1'b0);
    exp_resp(3, 16'hA5C3);
    exp_req(0, REQ_FETCH, 64'h0000_0000_0000_0100, 16'h2222, 1'b0);
    wait_grant(3);
    clr_req(3);
    i_pe_rready = 4'b0111;
    set_req(0, REQ_FETCH, 64'h0000_0000_0000_0100, 16'h2222);
    @(negedge i_clk); chk("t2b_no_grant_issue", o_pe_ready, 0);
    step();
    i_cache_data = 16'hA5C3; i_cache_data_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge i_clk);
      chk("t2b_rvalid_owner", o_pe_rvalid, 4'b1000);
      chk("t2b_cdr_low", o_cache_data_ready, 0);
      chk("t2b_no_grant_wait", o_pe_ready, 0);
      step();
    end
    i_pe_rready = 4'b1111;
    @(negedge i_clk); chk("t2b_cdr_high", o_cache_data_ready, 1);
    step();
    i_cache_data_valid = 1'b0;
    wait_grant(0);
    clr_req(0);
    step();

    // WRITE from PE2 stalled by the cache; PE1 must wait
    i_type_ready = 1'b0;
    set_req(2, REQ_WRITE, 64'h1234_5678_9ABC_DEF0, 16'h5A5A);
    exp_req(2, REQ_WRITE, 64'h1234_5678_9ABC_DEF0, 16'h5A5A, 1'b0);
    exp_req(1, REQ_FETCH, 64'h0000_0000_0000_0200, 16'h3333, 1'b0);
    wait_grant(2);
    clr_req(2);
    set_req(1, REQ_FETCH, 64'h0000_0000_0000_0200, 16'h3333);
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      chk("t4_tv_held", o_type_valid, 1);
      chk("t4_fields_stable", {o_request_type, o_addr, o_data}, {REQ_WRITE, 64'h1234_5678_9ABC_DEF0, 16'h5A5A});
      chk("t4_no_grant", o_pe_ready, 0);
      step();
    end
    i_type_ready = 1'b1;
    step();
    wait_grant(1);
    clr_req(1);
    step();

    // Illegal type from PE0 is dropped with an error pulse; pointer moves to 1
    set_req(0, 4'b0011, 64'h0000_0000_0000_0300, 16'h4444);
    exp_req(0, 4'b0011, 64'h0000_0000_0000_0300, 16'h4444, 1'b1);
    wait_grant(0);
    clr_req(0);
    @(negedge i_clk);
    chk("t5_no_tv", o_type_valid, 0);
    chk("t5_not_busy", o_busy, 0);
    chk("t5_err_once", o_err, 0);
    step();
    set_req(0, REQ_FETCH, 64'h0000_0000_0000_0400, 16'h5555);
    set_req(1, REQ_FETCH, 64'h0000_0000_0000_0500, 16'h6666);
    exp_req(1, REQ_FETCH, 64'h0000_0000_0000_0500, 16'h6666, 1'b0);
    exp_req(0, REQ_FETCH, 64'h0000_0000_0000_0400, 16'h5555, 1'b0);
    wait_grant(1);
    clr_req(1);
    wait_grant(0);
    clr_req(0);
    step();

    // Reset during WAIT_RESP with a beat on offer
    set_req(1, REQ_READ, 64'h0000_0000_0000_0600, 16'h0);
    exp_req(1, REQ_READ, 64'h0000_0000_0000_0600, 16'h0, 1'b0);
    wait_grant(1);
    clr_req(1);
    step();
    i_cache_data = 16'h7777; i_cache_data_valid = 1'b1;
    #1;
    chk("t6_rvalid_before", o_pe_rvalid, 4'b0010);
    chk("t6_cdr_before", o_cache_data_ready, 1);
    #1 i_nreset = 1'b0;
    #1;
    chk("t6_rvalid_rst", o_pe_rvalid, 0);
    chk("t6_busy_rst", o_busy, 0);
    chk("t6_cdr_rst", o_cache_data_ready, 0);
    chk("t6_state_rst", {o_type_valid, o_grant_id, o_request_type, o_addr}, 0);
    step();
    i_cache_data_valid = 1'b0;
    i_nreset = 1'b1;
    step();

    // All PEs hold FETCH: order 0,1,2,3,0 at one grant per two cycles
    for (int k = 0; k < 4; k++) begin
      set_req(k, REQ_FETCH, 64'h0000_0000_0000_1000 + 64'(k), 16'h00A0 + 16'(k));
      exp_req(k, REQ_FETCH, 64'h0000_0000_0000_1000 + 64'(k), 16'h00A0 + 16'(k), 1'b0);
    end
    exp_req(0, REQ_FETCH, 64'h0000_0000_0000_1000, 16'h00A0, 1'b0);
    for (int c = 0; c < 9; c++) begin
      logic [3:0] oh;
      oh = 4'b0001 << ((c / 2) % 4);
      @(negedge i_clk);
      if (c % 2 == 1) begin
        chk("t3_gap_ready", o_pe_ready, 0);
        chk("t3_gap_tv", o_type_valid, 1);
      end else chk("t3_rr_order", o_pe_ready, oh);
      step();
    end
    i_pe_valid = '0;
    step(); step();

    chk("grant_queue_drained", gq.size(), 0);
    chk("issue_queue_drained", iq.size(), 0);
    chk("resp_queue_drained", rq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fiber_req_arbiter.md
# fiber_req_arbiter

Shares the single PE-side request port of the fiber cache between `NUM_PE` processing elements. Each PE request is arbitrated round-robin, latched, and issued to the cache. For READ and CONSUME requests, the one returned data beat is routed back to the requesting PE. The block sits between the PE crossbar and the `fiber` cache instance and holds at most one request in flight.

## Interface
- `NUM_PE`, default 4: number of requesters, ≥2.
- `ADDR_WIDTH`, default 64: request address width.
- `DATA_WIDTH`, default 16: data beat width.
- `i_clk  in  1`: single clock, rising edge.
- `i_nreset  in  1`: asynchronous, active-low reset.
- `i_pe_valid  in  NUM_PE`: per-PE request valid.
- `o_pe_ready  out  NUM_PE`: per-PE request accepted; one-hot or zero.
- `i_pe_req_type  in  4*NUM_PE`: one-hot type per PE, slice k = bits [4k+3:4k].
- `i_pe_addr  in  ADDR_WIDTH*NUM_PE`: address per PE.
- `i_pe_wdata  in  DATA_WIDTH*NUM_PE`: write data per PE.
- `o_pe_rdata  out  DATA_WIDTH`: response data, broadcast to all PEs.
- `o_pe_rvalid  out  NUM_PE`: response valid, one-hot to the owner.
- `i_pe_rready  in  NUM_PE`: per-PE response ready.
- `o_request_type  out  4`, `o_addr  out  ADDR_WIDTH`, `o_data  out  DATA_WIDTH`: latched request to the cache.
- `o_type_valid  out  1`, `i_type_ready  in  1`: cache request handshake.
- `i_cache_data  in  DATA_WIDTH`, `i_cache_data_valid  in  1`, `o_cache_data_ready  out  1`: cache response channel.
- `o_grant_id  out  $clog2(NUM_PE)`: owner of the current transaction.
- `o_busy  out  1`: high whenever state ≠ IDLE.
- `o_err  out  1`: one-cycle pulse when a request with an illegal type is dropped.

## Operation
- Request types: FETCH=4'b0001, READ=4'b0010, WRITE=4'b0100, CONSUME=4'b1000.
  - FETCH and WRITE are posted: no response.
  - READ and CONSUME each return exactly one beat.
- FSM states: IDLE, ISSUE, WAIT_RESP.
- IDLE:
  - If any `i_pe_valid` is set, grant the first valid PE found searching upward from `rr_ptr`, wrapping at NUM_PE.
  - Assert `o_pe_ready[g]` combinationally in that cycle.
  - Latch type, address and wdata; set `o_grant_id=g`; set `rr_ptr=(g+1) mod NUM_PE`.
  - Next state is ISSUE, or stays IDLE with an `o_err` pulse if the type is not one-hot (the request is consumed and dropped).
- ISSUE:
  - `o_type_valid=1` with the latched fields held stable.
  - When `i_type_ready` is seen: go to IDLE for FETCH/WRITE, or WAIT_RESP for READ/CONSUME.
- WAIT_RESP:
  - `o_pe_rvalid[g]=i_cache_data_valid`, `o_pe_rdata=i_cache_data`, `o_cache_data_ready=i_pe_rready[g]`.
  - On a completed transfer, go to IDLE.
  - Other PEs' `rvalid` stay 0; new requests are not granted.
- `o_cache_data_ready=0` outside WAIT_RESP. A cache beat arriving in any other state is not consumed.

## Timing
- Reset values: state IDLE, `rr_ptr=0`, `o_grant_id=0`. Latched type, address and data are 0, so `o_request_type=0`, `o_addr=0`, `o_data=0`. All valid/ready outputs are 0, as are `o_busy` and `o_err`.
- Request accepted in cycle N → `o_type_valid` high from N+1.
- Posted request with `i_type_ready` held high: issued in N+1, next grant possible in N+2. Sustained throughput is one request per 2 cycles.
- READ: the response transfer cycle R is followed by IDLE at R+1.
- `o_type_valid` is never withdrawn before `i_type_ready`. The latched fields do not change while it is high.
- A PE held valid is regranted only after every other valid PE has been granted once, so there is no starvation.
- Simultaneous requests from all PEs are served in order `rr_ptr`, `rr_ptr+1`, … with wrap-around.
- Asynchronous reset asserted mid-transaction forces all outputs to their reset values immediately. The in-flight transaction is abandoned; the cache is reset from the same net.

## Structure
- Shared package `fiber_pkg`:
  - request-type constants;
  - FSM state encoding;
  - the `is_onehot4` function.
- One sub-module, `fiber_rr_arbiter`: combinational round-robin pick from (`req` vector, `rr_ptr`) to (`gnt_valid`, `gnt_id`). The FSM, latches and routing stay in the top module.

## Test plan
- Single FETCH from PE2, addr 64'h0000_0000_FFFF_FFFF, `i_type_ready=1` → `o_pe_ready=4'b0100` for one cycle. `o_type_valid` is high for one cycle with `o_request_type=4'b0001` and that address. `o_busy` is low again after 2 cycles.
- READ from PE1, cache returns 16'h0000 three cycles after issue → `o_pe_rvalid=4'b0010`, `o_pe_rdata=16'h0000`, and `o_grant_id=1` throughout.
- All 4 PEs hold FETCH from reset → grants in order 0,1,2,3,0; each PE is granted once per 8 cycles.
- `i_type_ready` held low for 5 cycles during a WRITE → `o_type_valid`, `o_addr` and `o_data` stay stable. No other `o_pe_ready` is asserted until the issue completes.
- PE0 sends type 4'b0011 → `o_pe_ready[0]` and `o_err` pulse together, no `o_type_valid`, and `rr_ptr` advances to 1.
- Reset asserted while in WAIT_RESP with `i_cache_data_valid` high → `o_pe_rvalid=0`, `o_busy=0` and `o_cache_data_ready=0` at once. After release, the first grant goes to PE0.
